// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

   // Which requester owns the read response returning next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   // Width of the fetch starvation age counter.
   typedef logic [3:0] age_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_age_ctr.sv
// Fetch starvation age counter. Clears whenever fetch is granted.
// Counts data wins under contention and saturates at STARVE_MAX.
module mem_arb_age_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam age_t AGE_MAX = age_t'(STARVE_MAX);

   age_t age_q;
   age_t age_d;

   // Next age: clear has priority over increment, and the count never passes AGE_MAX.
   always_comb begin
      age_d = age_q;
      if (clr_i) begin
         age_d = '0;
      end else if (inc_i && (age_q != AGE_MAX)) begin
         age_d = age_q + age_t'(1);
      end
   end

   // Age register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign at_max_o = (age_q == AGE_MAX);

endmodule : mem_arb_age_ctr

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the
// load/store path. Data has priority, except that fetch is forced to win
// once it has lost STARVE_MAX contended cycles in a row. Read data returns
// one cycle after the grant and is steered by the registered owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic [DWIDTH-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DWIDTH-1:0] d_rdata_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   owner_e owner_q;
   owner_e owner_d;
   logic   age_at_max;
   logic   age_inc;
   logic   age_clr;

   // Grants, memory drive and next response owner. Nothing is granted while
   // reset is held, so a read in that cycle can never produce an rvalid.
   always_comb begin
      if_gnt_o       = 1'b0;
      d_gnt_o        = 1'b0;
      mem_addr_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      owner_d        = OWN_NONE;
      age_inc        = 1'b0;
      age_clr        = 1'b0;

      if (rst) begin
         if (if_req_i && (!d_req_i || age_at_max)) begin
            if_gnt_o = 1'b1;
         end else if (d_req_i) begin
            d_gnt_o = 1'b1;
         end
         age_inc = if_req_i && d_gnt_o;
         age_clr = if_gnt_o;
      end

      if (if_gnt_o) begin
         mem_addr_o    = if_addr_i;
         mem_read_en_o = 1'b1;
         owner_d       = OWN_IF;
      end else if (d_gnt_o) begin
         mem_addr_o     = d_addr_i;
         mem_read_en_o  = !d_we_i;
         mem_write_en_o = d_we_i;
         owner_d        = d_we_i ? OWN_NONE : OWN_D;
      end
   end

   // Response owner register. Reset drops any read that is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   mem_arb_age_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_age_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (age_inc),
      .clr_i    (age_clr),
      .at_max_o (age_at_max)
   );

   assign mem_data_o  = d_wdata_i;
   assign if_rvalid_o = (owner_q == OWN_IF);
   assign d_rvalid_o  = (owner_q == OWN_D);
   assign if_rdata_o  = mem_data_i;
   assign d_rdata_o   = mem_data_i;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural model of the arbiter.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SMAX = 4;

   logic          clk;
   logic          rst;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_gnt_o;
   logic          d_rvalid_o;
   logic [DW-1:0] d_rdata_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
   logic          mem_read_en_o;
   logic          mem_write_en_o;
   logic [DW-1:0] mem_data_i;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(
      .AWIDTH     (AW),
      .DWIDTH     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_gnt_o       (if_gnt_o),
      .if_rvalid_o    (if_rvalid_o),
      .if_rdata_o     (if_rdata_o),
      .d_req_i        (d_req_i),
      .d_we_i         (d_we_i),
      .d_addr_i       (d_addr_i),
      .d_wdata_i      (d_wdata_i),
      .d_gnt_o        (d_gnt_o),
      .d_rvalid_o     (d_rvalid_o),
      .d_rdata_o      (d_rdata_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_read_en_o  (mem_read_en_o),
      .mem_write_en_o (mem_write_en_o),
      .mem_data_i     (mem_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Advance to just after the next rising edge and refresh memory read data.
   task automatic cyc();
      @(posedge clk);
      #1;
      mem_data_i = $urandom;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic we, input logic [31:0] da, input logic [31:0] wd);
      if_req_i  = ir;
      if_addr_i = ia;
      d_req_i   = dr;
      d_we_i    = we;
      d_addr_i  = da;
      d_wdata_i = wd;
   endtask

   // Behavioural model: starvation count as a plain integer, and the one
   // outstanding read tracked as "who is owed data next cycle".
   int            m_age  = 0;
   int            m_owed = 0;   // 0 nobody, 1 fetch, 2 data
   bit            e_ig, e_dg, e_re, e_we;
   logic [AW-1:0] e_addr;

   always @(negedge clk) begin
      e_ig   = 1'b0;
      e_dg   = 1'b0;
      e_addr = '0;
      if (rst) begin
         if (if_req_i && d_req_i) begin
            if (m_age >= SMAX) e_ig = 1'b1;
            else               e_dg = 1'b1;
         end else begin
            e_ig = if_req_i;
            e_dg = d_req_i;
         end
      end
      e_re = e_ig || (e_dg && !d_we_i);
      e_we = e_dg && d_we_i;
      if (e_ig)      e_addr = if_addr_i;
      else if (e_dg) e_addr = d_addr_i;

      check("m_if_gnt",   {31'd0, if_gnt_o},       {31'd0, e_ig});
      check("m_d_gnt",    {31'd0, d_gnt_o},        {31'd0, e_dg});
      check("m_rd_en",    {31'd0, mem_read_en_o},  {31'd0, e_re});
      check("m_wr_en",    {31'd0, mem_write_en_o}, {31'd0, e_we});
      check("m_addr",     mem_addr_o,              e_addr);
      check("m_if_rvld",  {31'd0, if_rvalid_o},    {31'd0, (rst && m_owed == 1)});
      check("m_d_rvld",   {31'd0, d_rvalid_o},     {31'd0, (rst && m_owed == 2)});
      check("m_if_rdata", if_rdata_o,              mem_data_i);
      check("m_d_rdata",  d_rdata_o,               mem_data_i);
      if (e_we) check("m_wdata", mem_data_o, d_wdata_i);

      if (!rst) begin
         m_age  = 0;
         m_owed = 0;
      end else begin
         if (e_ig)                       m_age = 0;
         else if (if_req_i && d_req_i)   m_age = m_age + 1;
         m_owed = e_ig ? 1 : ((e_dg && !d_we_i) ? 2 : 0);
      end
   end

   initial begin
      rst        = 1'b0;
      mem_data_i = '0;
      drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000, 32'h0);

      // Reset held with both requesting: everything quiet.
      repeat (3) begin
         cyc();
         #1;
         check("rst_if_gnt", {31'd0, if_gnt_o}, 32'd0);
         check("rst_d_gnt",  {31'd0, d_gnt_o}, 32'd0);
         check("rst_strobes", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
         check("rst_rvalid", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
         check("rst_addr",   mem_addr_o, 32'd0);
      end

      // Fetch alone, eligible in the first cycle out of reset.
      cyc();
      rst = 1'b1;
      drive(1'b1, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("f_gnt",  {31'd0, if_gnt_o}, 32'd1);
      check("f_rden", {31'd0, mem_read_en_o}, 32'd1);
      check("f_addr", mem_addr_o, 32'h0100_0000);

      // Contention with a store: data wins, fetch response from last cycle arrives.
      cyc();
      mem_data_i = 32'h1234_5678;
      drive(1'b1, 32'h0100_0000, 1'b1, 1'b1, 32'h0100_0040, 32'hDEAD_BEEF);
      #1;
      check("f_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      check("f_rdata",  if_rdata_o, 32'h1234_5678);
      check("c_d_gnt",  {31'd0, d_gnt_o}, 32'd1);
      check("c_if_gnt", {31'd0, if_gnt_o}, 32'd0);
      check("c_wren",   {31'd0, mem_write_en_o}, 32'd1);
      check("c_rden",   {31'd0, mem_read_en_o}, 32'd0);
      check("c_addr",   mem_addr_o, 32'h0100_0040);
      check("c_wdata",  mem_data_o, 32'hDEAD_BEEF);

      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("c_no_rvalid", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);

      // Fetch alone clears the age before the starvation run.
      cyc();
      drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("clr_gnt", {31'd0, if_gnt_o}, 32'd1);

      // Continuous contention: D D D D F D D D D F.
      for (int i = 0; i < 10; i++) begin
         cyc();
         drive(1'b1, 32'h0000_0100 + i, 1'b1, 1'b0, 32'h0000_0800 + i, 32'h0);
         #1;
         check("starve_if_gnt", {31'd0, if_gnt_o}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
         check("starve_d_gnt",  {31'd0, d_gnt_o},  (i == 4 || i == 9) ? 32'd0 : 32'd1);
      end

      // Alternating reads: fetch in N, data load in N+1.
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      drive(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("alt_if_gnt", {31'd0, if_gnt_o}, 32'd1);
      cyc();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
      #1;
      check("alt_d_gnt",   {31'd0, d_gnt_o}, 32'd1);
      check("alt_rv_n1",   {30'd0, if_rvalid_o, d_rvalid_o}, 32'd2);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("alt_rv_n2",   {30'd0, if_rvalid_o, d_rvalid_o}, 32'd1);
      cyc();
      #1;
      check("alt_rv_n3",   {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);

      // Reset right after a granted load drops its response.
      cyc();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
      #1;
      check("rm_d_gnt", {31'd0, d_gnt_o}, 32'd1);
      cyc();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("rm_rvalid0", {31'd0, d_rvalid_o}, 32'd0);
      cyc();
      #1;
      check("rm_rvalid1", {31'd0, d_rvalid_o}, 32'd0);
      cyc();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
      #1;
      check("rm_fresh_gnt",  {31'd0, d_gnt_o}, 32'd1);
      check("rm_fresh_addr", mem_addr_o, 32'h0000_0500);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("rm_fresh_rvld", {31'd0, d_rvalid_o}, 32'd1);

      // Random traffic with occasional reset, checked by the model only.
      for (int i = 0; i < 400; i++) begin
         cyc();
         rst = ($urandom_range(0, 49) != 0);
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared, single-port instruction/data memory between the fetch stage and the load/store (data) path of the RISC-V core. Issues at most one memory access per cycle, routes each read response back to its requester one cycle later, and bounds fetch starvation with an age counter. Sits between `fetch`/the memory stage and the `memory` instance in the top level.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width
- `STARVE_MAX`, 4, consecutive lost fetch contentions before fetch is forced to win (1..15)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-low
- `if_req_i`  in  1  fetch read request
- `if_addr_i`  in  AWIDTH  fetch address
- `if_gnt_o`  out  1  fetch request accepted this cycle
- `if_rvalid_o`  out  1  fetch read data valid
- `if_rdata_o`  out  DWIDTH  fetch read data
- `d_req_i`  in  1  data request
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  AWIDTH  data address
- `d_wdata_i`  in  DWIDTH  store data
- `d_gnt_o`  out  1  data request accepted this cycle
- `d_rvalid_o`  out  1  load data valid
- `d_rdata_o`  out  DWIDTH  load data
- `mem_addr_o`  out  AWIDTH  memory address
- `mem_data_o`  out  DWIDTH  memory write data
- `mem_read_en_o`  out  1  memory read strobe
- `mem_write_en_o`  out  1  memory write strobe
- `mem_data_i`  in  DWIDTH  memory read data, valid the cycle after `mem_read_en_o`

## Operation
- Handshake: request accepted in cycle N iff `x_req_i && x_gnt_o` in N; requester holds req/addr/data stable until granted. Grant is combinational from current requests and state.
- Arbitration, single requester: that requester is granted. Both requesting: data wins, unless `age_q == STARVE_MAX`, then fetch wins.
- Age counter `age_q` (4 bits): +1 when both request and data wins; cleared when fetch is granted; unchanged otherwise; never exceeds `STARVE_MAX`.
- Memory drive: granted port's address to `mem_addr_o`; `mem_read_en_o` = granted fetch, or granted data with `d_we_i=0`; `mem_write_en_o` = granted data with `d_we_i=1`; `mem_data_o` = `d_wdata_i` (don't-care on reads). No grant: both strobes 0, `mem_addr_o` = 0.
- Response owner register `owner_q` (`OWN_NONE`, `OWN_IF`, `OWN_D`): loaded every cycle with the owner of the read issued that cycle, else `OWN_NONE`.
- `if_rvalid_o` = (`owner_q == OWN_IF`); `d_rvalid_o` = (`owner_q == OWN_D`); both rdata outputs = `mem_data_i` unconditionally. Stores produce no rvalid.
- Reset (`rst`=0): `owner_q`=`OWN_NONE`, `age_q`=0; all grants, strobes, rvalids are 0; `mem_addr_o`=0. In-flight read response is dropped.

## Timing
- Grant latency 0 cycles (same cycle as request when winning). Read data latency exactly 1 cycle after grant. Write completes in the grant cycle.
- Throughput one access per cycle; back-to-back reads from alternating ports each get their own rvalid in the following cycle.
- Request in cycle N with `rst` deasserted in N: eligible in N. A read granted in the cycle `rst` asserts produces no rvalid.
- `STARVE_MAX` boundary: after `STARVE_MAX` consecutive data wins under contention, the next contended cycle grants fetch.

## Structure
- Package `mem_arb_pkg`: `owner_e` enum (`OWN_NONE`, `OWN_IF`, `OWN_D`) and 4-bit `age_t`.
- Sub-module `mem_arb_age_ctr`: saturating/clearing age counter with `inc`, `clr`, `at_max` outputs; rest inline in `mem_arbiter`.

## Test plan
- Reset: hold `rst`=0 with both reqs high -> all grants/strobes/rvalids 0, `mem_addr_o`=0.
- Fetch only: `if_req_i`=1, `if_addr_i`=0x0100_0000 -> `if_gnt_o`=1, `mem_read_en_o`=1 same cycle; next cycle `if_rvalid_o`=1, `if_rdata_o`=`mem_data_i`.
- Contention: both req, `d_we_i`=1, `d_addr_i`=0x0100_0040, `d_wdata_i`=0xDEAD_BEEF -> `d_gnt_o`=1, `mem_write_en_o`=1, `if_gnt_o`=0, no rvalid next cycle.
- Starvation, STARVE_MAX=4: both req continuously -> data granted cycles 0-3, fetch granted cycle 4, data cycles 5-8, fetch cycle 9.
- Alternating reads: fetch load N, data load N+1 -> `if_rvalid_o` at N+1, `d_rvalid_o` at N+2, never both high.
- Reset mid-read: data load granted, `rst`=0 next cycle -> `d_rvalid_o` stays 0; after release, fresh request served normally.
